// File: rtl/transpose_pkg.sv
// Shared types and sizing helpers for the streaming tile-transpose controller.
package transpose_pkg;

    // Controller phases: wait for start, fill the tile, replay it transposed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Width of the optional stall counter.
    localparam int STALL_CNT_W = 16;

    // Index counter width for a dimension: clog2, never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/transpose_tile_buf.sv
// Tile buffer: ROWS x COLS elements in plain flops, one synchronous write
// port and one combinational read port. Contents are intentionally not reset.
module transpose_tile_buf
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ROWS       = 4,
    parameter int COLS       = 8,
    parameter int RW         = cnt_w(ROWS),
    parameter int CW         = cnt_w(COLS)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [RW-1:0]         wr_r_i,
    input  logic [CW-1:0]         wr_c_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [RW-1:0]         rd_r_i,
    input  logic [CW-1:0]         rd_c_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [ROWS-1:0][COLS-1:0][DATA_WIDTH-1:0] mem_q;

    // Element write; no reset since stale data is never read before a refill.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_r_i][wr_c_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_r_i][rd_c_i];

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Streaming tile-transpose controller: loads one IN_ROWS x IN_COLS matrix
// row-major and replays it column-major through a registered output stage.
// Optional build macro TRANSPOSE_CTRL_STATS_EN adds a saturating stall_cnt
// output counting drain cycles where the downstream back-pressures.
module transpose_stream_ctrl
    import transpose_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IN_ROWS    = 4,
    parameter int IN_COLS    = 8
) (
    input  logic                   clk_p,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_row_end,
    output logic                   out_last
`ifdef TRANSPOSE_CTRL_STATS_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    localparam int RW = cnt_w(IN_ROWS);
    localparam int CW = cnt_w(IN_COLS);
    localparam logic [RW-1:0] R_MAX = RW'(IN_ROWS - 1);
    localparam logic [CW-1:0] C_MAX = CW'(IN_COLS - 1);

    state_e                  state_q, state_d;
    logic [RW-1:0]           wr_r_q, rd_r_q;
    logic [CW-1:0]           wr_c_q, rd_c_q;
    logic                    rd_done_q;
    logic                    done_q;
    logic                    out_valid_q, out_row_end_q, out_last_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic [DATA_WIDTH-1:0]   rdata;

    logic in_acc, wr_last, rd_last, ld_out, out_hs;

    assign in_ready = (state_q == LOAD);
    assign busy     = (state_q != IDLE);
    assign in_acc   = in_valid && in_ready;
    assign wr_last  = in_acc && (wr_r_q == R_MAX) && (wr_c_q == C_MAX);
    assign rd_last  = (rd_r_q == R_MAX) && (rd_c_q == C_MAX);
    assign out_hs   = out_valid_q && out_ready;
    // Refill the output register whenever it is empty or being consumed,
    // as long as the tile still has unread elements.
    assign ld_out   = (state_q == DRAIN) && !rd_done_q && (!out_valid_q || out_ready);

    transpose_tile_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .ROWS       (IN_ROWS),
        .COLS       (IN_COLS),
        .RW         (RW),
        .CW         (CW)
    ) u_buf (
        .clk_i   (clk_p),
        .we_i    (in_acc),
        .wr_r_i  (wr_r_q),
        .wr_c_i  (wr_c_q),
        .wdata_i (in_data),
        .rd_r_i  (rd_r_q),
        .rd_c_i  (rd_c_q),
        .rdata_o (rdata)
    );

    // Next state; DRAIN lingers through the done cycle so a start there is dropped.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)   state_d = LOAD;
            LOAD:    if (wr_last) state_d = DRAIN;
            DRAIN:   if (done_q)  state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // State and write/read index counters (row-major writes, column-major reads).
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wr_r_q  <= '0;
            wr_c_q  <= '0;
            rd_r_q  <= '0;
            rd_c_q  <= '0;
        end else begin
            state_q <= state_d;
            if (in_acc) begin
                if (wr_c_q == C_MAX) begin
                    wr_c_q <= '0;
                    wr_r_q <= (wr_r_q == R_MAX) ? '0 : wr_r_q + 1'b1;
                end else begin
                    wr_c_q <= wr_c_q + 1'b1;
                end
            end
            if (ld_out) begin
                if (rd_r_q == R_MAX) begin
                    rd_r_q <= '0;
                    rd_c_q <= (rd_c_q == C_MAX) ? '0 : rd_c_q + 1'b1;
                end else begin
                    rd_r_q <= rd_r_q + 1'b1;
                end
            end
        end
    end

    // Output register with row/last qualifiers; holds while stalled.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_row_end_q <= 1'b0;
            out_last_q    <= 1'b0;
            rd_done_q     <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            if (ld_out) begin
                out_data_q    <= rdata;
                out_row_end_q <= (rd_r_q == R_MAX);
                out_last_q    <= rd_last;
                out_valid_q   <= 1'b1;
            end else if (out_hs) begin
                out_valid_q   <= 1'b0;
            end
            if (state_q != DRAIN)      rd_done_q <= 1'b0;
            else if (ld_out && rd_last) rd_done_q <= 1'b1;
            done_q <= out_hs && out_last_q;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_row_end = out_row_end_q;
    assign out_last    = out_last_q;
    assign done        = done_q;

`ifdef TRANSPOSE_CTRL_STATS_EN
    logic [STALL_CNT_W-1:0] stall_q;

    // Saturating back-pressure counter, cleared by each accepted start.
    always_ff @(posedge clk_p or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == IDLE && start) begin
            stall_q <= '0;
        end else if (state_q == DRAIN && out_valid_q && !out_ready && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Self-checking bench for transpose_stream_ctrl on a 2x3 tile.
module tb_transpose_stream_ctrl;
    localparam int DW = 8;
    localparam int R  = 2;
    localparam int C  = 3;

    logic          clk_p = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          busy, done, in_ready, out_valid, out_row_end, out_last;
    logic [DW-1:0] out_data;
`ifdef TRANSPOSE_CTRL_STATS_EN
    logic [15:0]   stall_cnt;
`endif

    transpose_stream_ctrl #(.DATA_WIDTH(DW), .IN_ROWS(R), .IN_COLS(C)) dut (
        .clk_p       (clk_p),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_row_end (out_row_end),
        .out_last    (out_last)
`ifdef TRANSPOSE_CTRL_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk_p = ~clk_p;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: expected output stream = transpose of the matrix loaded.
    typedef struct {
        logic [DW-1:0] d;
        logic          re;
        logic          last;
    } exp_t;
    exp_t          exp_q[$];
    logic [DW-1:0] log_d[$];
    logic          log_re[$];
    logic          log_last[$];

    task automatic push_matrix(input int base);
        for (int c = 0; c < C; c++)
            for (int r = 0; r < R; r++)
                exp_q.push_back('{d: DW'(base + r * C + c), re: (r == R - 1),
                                  last: (r == R - 1 && c == C - 1)});
        log_d.delete();
        log_re.delete();
        log_last.delete();
    endtask

    // Downstream ready pattern: 0 = always ready, 1 = random, 2 = stalled.
    int rdy_mode = 0;
    always @(posedge clk_p) begin
        #2;
        if (rdy_mode == 0)      out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else                    out_ready = 1'b0;
    end

    // Per-cycle compare against the model, plus hold-stability and done timing.
    bit            exp_done = 0;
    bit            hold = 0;
    logic [DW-1:0] hd;
    logic          hre, hlast;
    always @(negedge clk_p) begin
        if (!rst_n) begin
            exp_done = 0;
            hold     = 0;
        end else begin
            chk("done_timing", done, exp_done);
            exp_done = 0;
            if (hold) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, hd);
                chk("hold_row_end", out_row_end, hre);
                chk("hold_last", out_last, hlast);
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL extra_output: got %0d expected no output", out_data);
                end else begin
                    chk("out_data", out_data, exp_q[0].d);
                    chk("out_row_end", out_row_end, exp_q[0].re);
                    chk("out_last", out_last, exp_q[0].last);
                    if (out_ready) begin
                        exp_done = exp_q[0].last;
                        log_d.push_back(out_data);
                        log_re.push_back(out_row_end);
                        log_last.push_back(out_last);
                        void'(exp_q.pop_front());
                    end
                end
            end
            hold  = out_valid && !out_ready;
            hd    = out_data;
            hre   = out_row_end;
            hlast = out_last;
        end
    end

    // Hand-computed literal check of a captured run.
    task automatic check_log(input string name, input int ref_d[6]);
        int ref_re[6];
        int ref_last[6];
        ref_re   = '{0, 1, 0, 1, 0, 1};
        ref_last = '{0, 0, 0, 0, 0, 1};
        chk({name, "_len"}, log_d.size(), 6);
        for (int i = 0; i < 6 && i < log_d.size(); i++) begin
            chk({name, "_d"}, log_d[i], ref_d[i]);
            chk({name, "_re"}, log_re[i], ref_re[i]);
            chk({name, "_last"}, log_last[i], ref_last[i]);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk_p); #1;
        start = 1'b0;
    endtask

    // Stream n elements base.. ; optional random gaps and a start pulse after k elements.
    task automatic send(input int base, input bit gaps, input int start_after, input int n);
        for (int i = 0; i < n; i++) begin
            bit acc;
            int t;
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                for (int k = 0; k < g; k++) begin
                    in_valid = 1'b0;
                    @(posedge clk_p); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = DW'(base + i);
            acc = 0;
            t   = 0;
            while (!acc && t < 100) begin
                @(negedge clk_p);
                acc = in_ready;
                @(posedge clk_p); #1;
                t++;
            end
            in_valid = 1'b0;
            if (!acc) begin
                n_chk++;
                n_fail++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 100 cycles");
            end
            if (i == start_after - 1) do_start();
        end
    endtask

    // Waits for the done pulse (bounded); busy must still be high in that cycle.
    task automatic wait_done(input string name);
        int t = 0;
        @(negedge clk_p);
        while (!done && t < 300) begin
            @(negedge clk_p);
            t++;
        end
        chk({name, "_done_seen"}, done, 1);
        chk({name, "_busy_at_done"}, busy, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int ref_a[6];
        int ref_b[6];
        int t;
        ref_a = '{1, 4, 2, 5, 3, 6};
        ref_b = '{10, 13, 11, 14, 12, 15};

        // Reset values
        repeat (2) @(negedge clk_p);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_row_end", out_row_end, 0);
        chk("rst_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        @(posedge clk_p); #1;
        rst_n = 1'b1;
        @(posedge clk_p); #1;

        // Basic run with full throughput and latency checks
        push_matrix(1);
        do_start();
        send(1, 0, 0, 6);
        @(negedge clk_p); chk("lat_first_cycle", out_valid, 0);
        @(negedge clk_p); chk("lat_second_cycle", out_valid, 1);
        wait_done("t1");
        @(negedge clk_p); chk("t1_busy_after", busy, 0);
        check_log("t1", ref_a);
        @(posedge clk_p); #1;

        // Random input gaps and random back-pressure
        rdy_mode = 1;
        push_matrix(1);
        do_start();
        send(1, 1, 0, 6);
        wait_done("t2");
        rdy_mode = 0;
        check_log("t2", ref_a);
        @(posedge clk_p); #1;

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 8'd9;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_p);
            chk("idle_in_ready", in_ready, 0);
            chk("idle_busy", busy, 0);
        end
        @(posedge clk_p); #1;
        in_valid = 1'b0;
        push_matrix(1);
        do_start();
        send(1, 0, 0, 6);
        wait_done("t3");
        check_log("t3", ref_a);
        @(posedge clk_p); #1;

        // start during LOAD, DRAIN and in the done cycle: all ignored
        push_matrix(1);
        do_start();
        send(1, 0, 3, 6);
        do_start();
        wait_done("t4");
        start = 1'b1;
        @(posedge clk_p); #1;
        start = 1'b0;
        @(negedge clk_p); chk("t4_no_restart_a", busy, 0);
        @(negedge clk_p); chk("t4_no_restart_b", busy, 0);
        chk("t4_no_restart_ready", in_ready, 0);
        check_log("t4", ref_a);
        @(posedge clk_p); #1;

        // Reset mid-load discards the partial matrix
        do_start();
        send(20, 0, 0, 4);
        chk("t5_loading", in_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_in_ready", in_ready, 0);
        chk("t5_rst_out_valid", out_valid, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_out_data", out_data, 0);
        chk("t5_rst_last", out_last, 0);
        @(posedge clk_p); #1;
        rst_n = 1'b1;
        @(posedge clk_p); #1;
        push_matrix(10);
        do_start();
        send(10, 0, 0, 6);
        wait_done("t5");
        check_log("t5", ref_b);
        @(posedge clk_p); #1;

        // Five stalled cycles after the first valid
        rdy_mode = 2;
        push_matrix(1);
        do_start();
        send(1, 0, 0, 6);
        t = 0;
        @(negedge clk_p);
        while (!out_valid && t < 50) begin
            @(negedge clk_p);
            t++;
        end
        chk("t6_first_valid", out_valid, 1);
        repeat (4) @(negedge clk_p);
        rdy_mode = 0;
        wait_done("t6");
        check_log("t6", ref_a);
`ifdef TRANSPOSE_CTRL_STATS_EN
        chk("t6_stall_cnt", stall_cnt, 5);
        @(negedge clk_p);
        chk("t6_stall_cnt_hold", stall_cnt, 5);
`endif
        chk("model_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
